// File: rtl/ite_select_pipe.sv
// N-way WIDTH-bit if-then-else select feeding a 2-entry valid/ready output buffer.
// The head register drives O/O_err directly, so there is no combinational path from I/S to O.
module ite_select_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 3,
  localparam int unsigned SEL_W = (N > 2) ? $clog2(N) : 1
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [N*WIDTH-1:0]   I,
  input  logic [SEL_W-1:0]     S,
  input  logic                 I_valid,
  output logic                 I_ready,
  output logic [WIDTH-1:0]     O,
  output logic                 O_err,
  output logic                 O_valid,
  input  logic                 O_ready
);

  localparam int unsigned CNT_W = 2;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  int unsigned      sel_idx;

  logic [WIDTH-1:0] head_data, tail_data;
  logic             head_err, tail_err;
  logic [CNT_W-1:0] count, count_nxt;
  logic             ready_q, valid_q;
  logic             push, pop;

  // Out-of-range selects fall back to the last channel and are flagged.
  always_comb begin
    sel_err  = (32'(S) >= N);
    sel_idx  = sel_err ? (N - 1) : 32'(S);
    sel_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (k == sel_idx) sel_data = I[k*WIDTH +: WIDTH];
    end
  end

  assign push = I_valid & ready_q;
  assign pop  = valid_q & O_ready;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Buffer storage; ready/valid flags are registered copies of the next occupancy.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      head_data <= '0;
      head_err  <= 1'b0;
      tail_data <= '0;
      tail_err  <= 1'b0;
      count     <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      count   <= count_nxt;
      ready_q <= (count_nxt != CNT_W'(2));
      valid_q <= (count_nxt != CNT_W'(0));
      if (push && (pop || count == CNT_W'(0))) begin
        head_data <= sel_data;
        head_err  <= sel_err;
      end else if (push) begin
        tail_data <= sel_data;
        tail_err  <= sel_err;
      end else if (pop && count == CNT_W'(2)) begin
        head_data <= tail_data;
        head_err  <= tail_err;
      end
    end
  end

  assign I_ready = ready_q;
  assign O_valid = valid_q;
  assign O       = head_data;
  assign O_err   = head_err;

endmodule
